// File: rtl/pwm_pkg.sv
// Shared definitions for the two-channel PWM peripheral: register map, CTRL bits,
// default counter width and the per-channel register selector.
package pwm_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;

    localparam logic [ADDR_W-1:0] CTRL_OFS   = 8'h00;
    localparam logic [ADDR_W-1:0] DIV_OFS    = 8'h04;
    localparam logic [ADDR_W-1:0] PERIOD_OFS = 8'h08;
    localparam logic [ADDR_W-1:0] DUTY_OFS   = 8'h0C;
    localparam logic [ADDR_W-1:0] CH_STRIDE  = 8'h10;
    localparam logic [ADDR_W-1:0] MAP_MASK   = 8'h1C;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_OE    = 1;
    localparam int CTRL_DIVEN = 2;
    localparam int CTRL_W     = 3;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'(CTRL_OFS >> 2),
        REG_DIV    = 2'(DIV_OFS >> 2),
        REG_PERIOD = 2'(PERIOD_OFS >> 2),
        REG_DUTY   = 2'(DUTY_OFS >> 2)
    } reg_sel_e;

    // Only word-aligned offsets inside the two channel windows are mapped.
    function automatic logic addr_in_map(input logic [ADDR_W-1:0] addr);
        return (addr & ~(MAP_MASK | CH_STRIDE)) == '0;
    endfunction

endpackage

// File: rtl/pwm_if.sv
// Peripheral-bus register port: single-cycle write strobe, combinational read data.
interface pwm_if;
    import pwm_pkg::*;

    logic              write;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [DATA_W-1:0] rdata_o;

    modport master (output write, addr_i, wdata_i, input rdata_o);
    modport slave  (input write, addr_i, wdata_i, output rdata_o);

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: programmed registers, active shadow copies, prescaler,
// period counter and duty compare.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_i,
    input  reg_sel_e          sel_i,
    input  logic [CNT_W-1:0]  wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              pwm_o,
    output logic              oe_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  div_q, div_d, period_q, period_d, duty_q, duty_d;
    logic [CNT_W-1:0]  div_act_q, div_act_d, period_act_q, period_act_d;
    logic [CNT_W-1:0]  duty_act_q, duty_act_d;
    logic [CNT_W-1:0]  pre_q, pre_d, cnt_q, cnt_d;

    logic en, tick, period_last, wrap;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q       <= '0;
            div_q        <= '0;
            period_q     <= '0;
            duty_q       <= '0;
            div_act_q    <= '0;
            period_act_q <= '0;
            duty_act_q   <= '0;
            pre_q        <= '0;
            cnt_q        <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            div_q        <= div_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
            div_act_q    <= div_act_d;
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        div_d    = div_q;
        period_d = period_q;
        duty_d   = duty_q;
        if (wr_i) begin
            case (sel_i)
                REG_CTRL:   ctrl_d   = wdata_i[CTRL_W-1:0];
                REG_DIV:    div_d    = wdata_i;
                REG_PERIOD: period_d = wdata_i;
                REG_DUTY:   duty_d   = wdata_i;
                default:    ;
            endcase
        end
    end

    // DIV of 0 or 1 both mean "every clock"; PERIOD of 0 counts as a wrap on every tick
    // so a stopped channel can still pick up newly programmed values.
    always_comb begin
        en          = ctrl_q[CTRL_EN];
        tick        = !ctrl_q[CTRL_DIVEN] || (div_act_q <= ONE) || (pre_q == div_act_q - ONE);
        period_last = (period_act_q == '0) || (cnt_q == period_act_q - ONE);
        wrap        = en && tick && period_last;

        pre_d = pre_q + ONE;
        if (!en || tick) begin
            pre_d = '0;
        end

        cnt_d = cnt_q;
        if (!en || period_act_q == '0) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = period_last ? '0 : cnt_q + ONE;
        end

        div_act_d    = div_act_q;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        if (!en || wrap) begin
            div_act_d    = div_q;
            period_act_d = period_q;
            duty_act_d   = duty_q;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (sel_i)
            REG_CTRL:   rdata_o[CTRL_W-1:0] = ctrl_q;
            REG_DIV:    rdata_o[CNT_W-1:0]  = div_q;
            REG_PERIOD: rdata_o[CNT_W-1:0]  = period_q;
            REG_DUTY:   rdata_o[CNT_W-1:0]  = duty_q;
            default:    rdata_o = '0;
        endcase
    end

    assign pwm_o = en && (period_act_q != '0) && (cnt_q < duty_act_q);
    assign oe_o  = ctrl_q[CTRL_OE];

endmodule

// File: rtl/pwm_2ch.sv
// Two-channel memory-mapped PWM peripheral: address decode, write demux and read mux
// around two independent pwm_channel instances.
module pwm_2ch
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic  clk_i,
    input  logic  rst_i,
    pwm_if.slave  bus,
    output logic  o_pwm,
    output logic  o_pwm_2,
    output logic  oe_pwm1,
    output logic  oe_pwm2
);

    logic              in_map, ch2_sel, wr_ch1, wr_ch2;
    reg_sel_e          sel;
    logic [DATA_W-1:0] rdata_ch1, rdata_ch2;
    logic              unused_wdata;

    assign in_map  = addr_in_map(bus.addr_i);
    assign ch2_sel = (bus.addr_i & CH_STRIDE) != '0;
    assign sel     = reg_sel_e'(bus.addr_i[3:2]);
    assign wr_ch1  = bus.write && in_map && !ch2_sel;
    assign wr_ch2  = bus.write && in_map && ch2_sel;

    // Upper write-data bits beyond the counter width are deliberately dropped.
    assign unused_wdata = ^bus.wdata_i[DATA_W-1:CNT_W];

    pwm_channel #(.CNT_W(CNT_W)) u_ch1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_i    (wr_ch1),
        .sel_i   (sel),
        .wdata_i (bus.wdata_i[CNT_W-1:0]),
        .rdata_o (rdata_ch1),
        .pwm_o   (o_pwm),
        .oe_o    (oe_pwm1)
    );

    pwm_channel #(.CNT_W(CNT_W)) u_ch2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_i    (wr_ch2),
        .sel_i   (sel),
        .wdata_i (bus.wdata_i[CNT_W-1:0]),
        .rdata_o (rdata_ch2),
        .pwm_o   (o_pwm_2),
        .oe_o    (oe_pwm2)
    );

    always_comb begin
        bus.rdata_o = '0;
        if (in_map) begin
            bus.rdata_o = ch2_sel ? rdata_ch2 : rdata_ch1;
        end
    end

endmodule

// File: tb/tb_pwm_2ch.sv
// Directed self-checking bench for pwm_2ch: register map, PWM waveforms,
// duty shadowing and asynchronous reset.
module tb_pwm_2ch;

    logic clk_i = 1'b0;
    logic rst_i;
    logic o_pwm, o_pwm_2, oe_pwm1, oe_pwm2;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   start1, start2, w_cyc, eff, ph1, ph2, guard;
    logic exp_b;

    pwm_if bus ();

    pwm_2ch dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .bus     (bus),
        .o_pwm   (o_pwm),
        .o_pwm_2 (o_pwm_2),
        .oe_pwm1 (oe_pwm1),
        .oe_pwm2 (oe_pwm2)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp_v, $time);
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_i);
        bus.write   = 1'b1;
        bus.addr_i  = a;
        bus.wdata_i = d;
        @(negedge clk_i);
        bus.write   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp_v);
        bus.addr_i = a;
        #1;
        check(tag, bus.rdata_o, exp_v);
    endtask

    initial begin
        rst_i       = 1'b1;
        bus.write   = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_outs_held", {28'h0, o_pwm, o_pwm_2, oe_pwm1, oe_pwm2}, 32'h0);
        rst_i = 1'b0;

        // 1: reset state
        @(negedge clk_i);
        check("rst_outs", {28'h0, o_pwm, o_pwm_2, oe_pwm1, oe_pwm2}, 32'h0);
        for (int i = 0; i < 8; i++) rd_chk("rst_reg", 8'(i * 4), 32'h0);
        rd_chk("rst_unmapped", 8'h20, 32'h0);

        // 2: duty >= period -> constant high; truncation and CTRL masking on readback
        bus_wr(8'h04, 32'hABCD_0002);
        bus_wr(8'h08, 32'd3);
        bus_wr(8'h0C, 32'd5);
        bus_wr(8'h00, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) begin
            check("t2_pwm1", {31'h0, o_pwm}, 32'd1);
            check("t2_oe1", {31'h0, oe_pwm1}, 32'd1);
            check("t2_ch2_idle", {30'h0, o_pwm_2, oe_pwm2}, 32'd0);
            @(negedge clk_i);
        end
        rd_chk("t2_ctrl", 8'h00, 32'd7);
        rd_chk("t2_div", 8'h04, 32'd2);
        rd_chk("t2_period", 8'h08, 32'd3);
        rd_chk("t2_duty", 8'h0C, 32'd5);

        // 3: DIV=2, PERIOD=4, DUTY=1 -> 2 high, 6 low
        bus_wr(8'h00, 32'd0);
        bus_wr(8'h08, 32'd4);
        bus_wr(8'h0C, 32'd1);
        bus_wr(8'h00, 32'd7);
        start1 = cyc;
        for (int i = 0; i < 16; i++) begin
            ph1 = (cyc - start1) % 8;
            check("t3_pwm1", {31'h0, o_pwm}, {31'h0, ph1 < 2});
            @(negedge clk_i);
        end

        // 4: channel 2 with DUTY=2 alongside channel 1
        bus_wr(8'h14, 32'd2);
        bus_wr(8'h18, 32'd4);
        bus_wr(8'h1C, 32'd2);
        bus_wr(8'h10, 32'd7);
        start2 = cyc;
        for (int i = 0; i < 16; i++) begin
            ph1 = (cyc - start1) % 8;
            ph2 = (cyc - start2) % 8;
            check("t4_pwm1", {31'h0, o_pwm}, {31'h0, ph1 < 2});
            check("t4_pwm2", {31'h0, o_pwm_2}, {31'h0, ph2 < 4});
            check("t4_oe2", {31'h0, oe_pwm2}, 32'd1);
            @(negedge clk_i);
        end
        rd_chk("t4_ch2_duty", 8'h1C, 32'd2);

        // 5: mid-period duty change lands on the next wrap
        guard = 0;
        while (((cyc - start1) % 8) != 3 && guard < 16) begin
            @(negedge clk_i);
            guard++;
        end
        check("t5_align", {31'h0, guard < 16}, 32'd1);
        bus_wr(8'h0C, 32'd3);
        w_cyc = cyc;
        eff   = start1 + (((w_cyc - start1) / 8) + 1) * 8;
        for (int i = 0; i < 24; i++) begin
            ph1   = (cyc - start1) % 8;
            ph2   = (cyc - start2) % 8;
            exp_b = (cyc >= eff) ? (ph1 < 6) : (ph1 < 2);
            check("t5_pwm1", {31'h0, o_pwm}, {31'h0, exp_b});
            check("t5_pwm2", {31'h0, o_pwm_2}, {31'h0, ph2 < 4});
            @(negedge clk_i);
        end
        rd_chk("t5_duty3", 8'h0C, 32'd3);
        bus_wr(8'h0C, 32'd0);
        repeat (16) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            check("t5_duty0", {31'h0, o_pwm}, 32'd0);
            @(negedge clk_i);
        end
        rd_chk("t5_duty0_rd", 8'h0C, 32'd0);

        // 6: async reset during high phase, then unmapped write
        bus_wr(8'h0C, 32'd5);
        guard = 0;
        while (o_pwm !== 1'b1 && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        check("t6_high_seen", {31'h0, guard < 20}, 32'd1);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_async_pwm1", {31'h0, o_pwm}, 32'd0);
        check("t6_async_pwm2", {31'h0, o_pwm_2}, 32'd0);
        check("t6_async_oe", {30'h0, oe_pwm1, oe_pwm2}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        bus_wr(8'h40, 32'hFFFF_FFFF);
        rd_chk("t6_unmapped", 8'h40, 32'h0);
        for (int i = 0; i < 8; i++) rd_chk("t6_reg", 8'(i * 4), 32'h0);
        repeat (4) @(negedge clk_i);
        check("t6_outs", {28'h0, o_pwm, o_pwm_2, oe_pwm1, oe_pwm2}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
